bmp_master_rx: RTL and testbench

Master-side receiver for the scheduler's output channel. Accepts 32-bit beats on `data_to_master` qualified by `mstr0_data_valid` and throttles them with `mstr0_ready`. Extracts the BMP header fields and buffers words in an internal FIFO for a downstream consumer. Reports file completion, short files, overflow and source-switch errors, so a whole BMP transfer can be recovered and checked at the master end.

---
 rtl/bmp_master_rx.sv | 143 ++++++++++++++
 tb/tb_bmp_master_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bmp_master_rx.sv
// Master-side BMP receiver: accepts scheduler beats, parses the header, buffers words in a FWFT FIFO.
// Build option BMP_RX_HDR_STRIP_EN keeps the 14 header beats out of the FIFO.
module bmp_master_rx #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int MAX_FILE_SIZE = 1000000,
  parameter int HEADER_BYTES  = 56,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BUS_SIZE-1:0] data_to_master,
  input  logic [1:0]               mstr0_data_valid,
  input  logic                     mstr0_cmplt,
  output logic                     mstr0_ready,
  output logic [DATA_BUS_SIZE-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_src,
  output logic [31:0]              file_size,
  output logic [31:0]              byte_count,
  output logic                     frame_done,
  output logic                     err_short,
  output logic                     err_ovf,
  output logic                     err_src
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_DONE} state_t;

  typedef struct packed {
    logic                     last;
    logic                     src;
    logic [DATA_BUS_SIZE-1:0] data;
  } word_t;

  function automatic logic [31:0] clamp_size(input logic [31:0] s);
    return (s < 32'(HEADER_BYTES) || s > 32'(MAX_FILE_SIZE)) ? 32'(HEADER_BYTES) : s;
  endfunction

  state_t      state, state_next;
  word_t       mem [FIFO_DEPTH];
  word_t       head;
  logic [AW:0] wr_ptr, rd_ptr, count, count_next;
  logic        src_id;

  logic        accept, in_file, done_beat, cut_short;
  logic        push_req, push, pop, full, ovf;
  logic [32:0] sum;
  logic [31:0] bc_new;

  assign accept  = mstr0_data_valid[0] && (state != S_DONE);
  assign in_file = (state == S_HDR) || (state == S_PIX);

  // Saturating byte counter; the first beat of a file restarts it.
  assign sum    = {1'b0, byte_count} + 33'd4;
  assign bc_new = (state == S_IDLE) ? 32'd4 : (sum[32] ? 32'hFFFF_FFFF : sum[31:0]);

  assign done_beat = accept && in_file && (bc_new >= 32'(HEADER_BYTES)) && (bc_new >= file_size);
  assign cut_short = mstr0_cmplt && in_file && !done_beat;

`ifdef BMP_RX_HDR_STRIP_EN
  assign push_req = accept && (state == S_PIX);
`else
  assign push_req = accept;
`endif

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign push       = push_req && (!full || pop);
  assign ovf        = push_req && full && !pop;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_data   = out_valid ? head.data : '0;
  assign out_last   = out_valid && head.last;
  assign out_src    = out_valid && head.src;
  assign frame_done = (state == S_DONE);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) state_next = S_HDR;
      S_HDR: begin
        if (done_beat || cut_short)                         state_next = S_DONE;
        else if (accept && bc_new >= 32'(HEADER_BYTES))     state_next = S_PIX;
      end
      S_PIX:  if (done_beat || cut_short) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; resetting the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{last: done_beat, src: mstr0_data_valid[1], data: data_to_master};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mstr0_ready <= 1'b0;
      file_size   <= '0;
      byte_count  <= '0;
      src_id      <= 1'b0;
      err_short   <= 1'b0;
      err_ovf     <= 1'b0;
      err_src     <= 1'b0;
    end else begin
      state <= state_next;
      // Room for the beat possibly in flight plus one beat of slack after ready falls.
      mstr0_ready <= (count_next <= (AW+1)'(FIFO_DEPTH - 3)) && (state_next != S_DONE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (accept) begin
        byte_count <= bc_new;
        if (state == S_IDLE) begin
          src_id    <= mstr0_data_valid[1];
          file_size <= {16'd0, data_to_master[7:0], data_to_master[15:8]};
          err_short <= 1'b0;
          err_src   <= 1'b0;
          err_ovf   <= ovf;
        end else begin
          if (state == S_HDR && byte_count == 32'd4)
            file_size <= clamp_size({data_to_master[23:16], data_to_master[31:24], file_size[15:0]});
          if (mstr0_data_valid[1] != src_id) err_src <= 1'b1;
          if (ovf) err_ovf <= 1'b1;
        end
      end

      if (cut_short) err_short <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmp_master_rx.sv
// Directed bench for bmp_master_rx: normal file, backpressure/overflow, reset, short file, source switch, clamp.
module tb_bmp_master_rx;

`ifdef BMP_RX_HDR_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_to_master = '0;
  logic [1:0]  mstr0_data_valid = '0;
  logic        mstr0_cmplt = 1'b0;
  logic        mstr0_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        out_src;
  logic [31:0] file_size;
  logic [31:0] byte_count;
  logic        frame_done;
  logic        err_short;
  logic        err_ovf;
  logic        err_src;

  int n_checks = 0;
  int n_bad    = 0;
  int pops     = 0;
  int lasts    = 0;

  bmp_master_rx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_to_master   (data_to_master),
    .mstr0_data_valid (mstr0_data_valid),
    .mstr0_cmplt      (mstr0_cmplt),
    .mstr0_ready      (mstr0_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .out_src          (out_src),
    .file_size        (file_size),
    .byte_count       (byte_count),
    .frame_done       (frame_done),
    .err_short        (err_short),
    .err_ovf          (err_ovf),
    .err_src          (err_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pops <= pops + 1;
      if (out_last) lasts <= lasts + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic id, input logic cmplt);
    data_to_master   = d;
    mstr0_data_valid = {id, 1'b1};
    mstr0_cmplt      = cmplt;
    tick();
    mstr0_data_valid = '0;
    mstr0_cmplt      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Beat k (1-based): beat 1 carries 'B','M' and size bytes 2,3; beat 2 carries size bytes 4,5.
  function automatic logic [31:0] beat_word(input int k, input logic [31:0] hdr0, input logic [31:0] hdr1);
    if (k == 1) return hdr0;
    if (k == 2) return hdr1;
    return 32'hA500_0000 | 32'(k);
  endfunction

  initial begin
    int p0, l0, sent;

    // Reset state
    tick();
    tick();
    check("rst_ready", mstr0_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fsize", file_size, 0);
    check("rst_bcount", byte_count, 0);
    check("rst_errs", {err_short, err_ovf, err_src, frame_done}, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", mstr0_ready, 1);

    // 64-byte file, consumer always ready
    out_ready = 1'b1;
    p0 = pops;
    l0 = lasts;
    for (int k = 1; k <= 16; k++) begin
      send_beat(beat_word(k, 32'h424D_4000, 32'h0), 1'b0, 1'b0);
      if (k == 2) check("f64_fsize", file_size, 64);
      if (k == 15) check("f64_no_last15", out_last, 0);
      if (k == 15) check("f64_no_done15", frame_done, 0);
    end
    check("f64_last16", out_last, 1);
    check("f64_data16", out_data, 32'hA500_0010);
    check("f64_bcount", byte_count, 64);
    check("f64_done", frame_done, 1);
    check("f64_ready_done", mstr0_ready, 0);
    tick();
    check("f64_done_once", frame_done, 0);
    check("f64_pops", pops - p0, STRIP ? 2 : 16);
    check("f64_lasts", lasts - l0, 1);
    check("f64_errs", {err_short, err_ovf, err_src}, 0);

    // Backpressure and overflow: header drained, then stall the consumer in pixel data
    for (int k = 1; k <= 14; k++) send_beat(beat_word(k, 32'h424D_E803, 32'h0), 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    check("ovf_ready_start", mstr0_ready, 1);
    sent = 0;
    while (mstr0_ready && sent < 10) begin
      send_beat(beat_word(15 + sent, 32'h0, 32'h0), 1'b0, 1'b0);
      sent++;
    end
    check("ovf_ready_fall_at6", sent, 6);
    send_beat(32'hBEEF_0001, 1'b0, 1'b0);
    send_beat(32'hBEEF_0002, 1'b0, 1'b0);
    check("ovf_full_no_err", err_ovf, 0);
    check("ovf_head", out_data, 32'hA500_000F);
    send_beat(32'hBEEF_0003, 1'b0, 1'b0);
    check("ovf_err", err_ovf, 1);
    check("ovf_bcount", byte_count, 23 * 4);

    // Mid-file reset
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_outs", {out_data, out_last, out_src}, 0);
    check("mid_rst_regs", {mstr0_ready, frame_done, err_short, err_ovf, err_src}, 0);
    check("mid_rst_bcount", byte_count, 0);
    check("mid_rst_fsize", file_size, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      send_beat(beat_word(k, 32'h424D_4000, 32'h0), 1'b0, 1'b0);
      if (k == 2) check("post_rst_fsize", file_size, 64);
    end
    check("post_rst_done", frame_done, 1);
    tick();

    // 100-byte file cut short after 80 bytes
    l0 = lasts;
    for (int k = 1; k <= 20; k++) send_beat(beat_word(k, 32'h424D_6400, 32'h0), 1'b0, 1'b0);
    check("short_fsize", file_size, 100);
    mstr0_cmplt = 1'b1;
    tick();
    mstr0_cmplt = 1'b0;
    check("short_err", err_short, 1);
    check("short_done", frame_done, 1);
    check("short_bcount", byte_count, 80);
    tick();
    check("short_idle_ready", mstr0_ready, 1);
    check("short_sticky", err_short, 1);
    check("short_no_last", lasts - l0, 0);

    // Completing beat coincides with cmplt: no short error
    for (int k = 1; k <= 16; k++) begin
      send_beat(beat_word(k, 32'h424D_4000, 32'h0), 1'b0, k == 16);
      if (k == 1) check("coinc_err_cleared", err_short, 0);
    end
    check("coinc_done", frame_done, 1);
    check("coinc_no_short", err_short, 0);
    tick();

    // Source id flips on beat 5
    for (int k = 1; k <= 6; k++) begin
      send_beat(beat_word(k, 32'h424D_6400, 32'h0), k == 5, 1'b0);
      if (k == 4) check("src_no_err", err_src, 0);
      if (k == 5) check("src_err", err_src, 1);
      if (k == 5) check("src_out", out_src, STRIP ? 0 : 1);
      if (k == 6) check("src_out_back", out_src, 0);
    end
    do_reset();
    tick();

    // Oversized file_size is clamped to the header length
    for (int k = 1; k <= 14; k++) begin
      send_beat(beat_word(k, 32'h424D_8084, 32'h1E00_0000), 1'b0, 1'b0);
      if (k == 2) check("clamp_fsize", file_size, 56);
      if (k == 13) check("clamp_no_done13", frame_done, 0);
    end
    check("clamp_done14", frame_done, 1);
    check("clamp_no_short", err_short, 0);
    tick();
    check("clamp_idle", frame_done, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
